// File: rtl/router_input_port.sv
// Router input port: one FIFO per VC fed from the NIC link, with credit and
// VC-free pulses returned to the NIC as flits are drained by the switch allocator.
module router_input_port #(
    parameter int FLIT_WIDTH    = 64,
    parameter int N_TOT_OF_VC   = 4,
    parameter int N_BITS_VC_ID  = 2,
    parameter int VC_ID_LSB     = 56,
    parameter int MAX_CREDIT    = 4,
    parameter int N_BITS_CREDIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH-1:0]   in_link_i,
    input  logic                    is_valid_i,
    output logic [N_TOT_OF_VC-1:0]  credit_signal_o,
    output logic [N_TOT_OF_VC-1:0]  free_signal_o,
    output logic [N_TOT_OF_VC-1:0]  vc_not_empty_o,
    output logic [N_TOT_OF_VC-1:0]  head_is_header_o,
    input  logic                    rd_i,
    input  logic [N_BITS_VC_ID-1:0] rd_vc_i,
    output logic [FLIT_WIDTH-1:0]   rd_flit_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int PTR_W = (MAX_CREDIT > 1) ? $clog2(MAX_CREDIT) : 1;
    localparam logic [N_BITS_CREDIT-1:0] FULL_COUNT = N_BITS_CREDIT'(MAX_CREDIT);
    localparam logic [PTR_W-1:0]         LAST_PTR   = PTR_W'(MAX_CREDIT - 1);

    logic [FLIT_WIDTH-1:0]    r_mem    [N_TOT_OF_VC][MAX_CREDIT];
    logic [PTR_W-1:0]         r_wr_ptr [N_TOT_OF_VC];
    logic [PTR_W-1:0]         r_rd_ptr [N_TOT_OF_VC];
    logic [N_BITS_CREDIT-1:0] r_count  [N_TOT_OF_VC];
    logic [N_TOT_OF_VC-1:0]   r_credit;
    logic [N_TOT_OF_VC-1:0]   r_free;
    logic                     r_overflow;
    logic                     r_underflow;

    logic [N_BITS_VC_ID-1:0]  w_wr_vc;
    logic                     w_wr_full;
    logic                     w_rd_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [FLIT_WIDTH-1:0]    w_rd_flit;
    logic [N_TOT_OF_VC-1:0]   w_push_vec;
    logic [N_TOT_OF_VC-1:0]   w_pop_vec;
    logic [N_TOT_OF_VC-1:0]   w_not_empty;
    logic [N_TOT_OF_VC-1:0]   w_header;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_wr_vc    = in_link_i[VC_ID_LSB +: N_BITS_VC_ID];
    assign w_wr_full  = (r_count[w_wr_vc] == FULL_COUNT);
    assign w_rd_empty = (r_count[rd_vc_i] == '0);
    assign w_pop      = rd_i && !w_rd_empty;
    // A pop of the same full VC in this edge frees the slot the write needs.
    assign w_push     = is_valid_i && (!w_wr_full || (w_pop && (rd_vc_i == w_wr_vc)));
    assign w_rd_flit  = r_mem[rd_vc_i][r_rd_ptr[rd_vc_i]];

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_push_vec = '0;
        w_pop_vec  = '0;
        if (w_push) w_push_vec[w_wr_vc] = 1'b1;
        if (w_pop)  w_pop_vec[rd_vc_i]  = 1'b1;
    end

    always_comb begin
        w_not_empty = '0;
        w_header    = '0;
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            w_not_empty[v] = (r_count[v] != '0);
            w_header[v]    = w_not_empty[v] && r_mem[v][r_rd_ptr[v]][FLIT_WIDTH-2];
        end
    end

    // NOTE: flit storage has no reset; emptiness comes from the counters, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_vc][r_wr_ptr[w_wr_vc]] <= in_link_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_credit    <= '0;
            r_free      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                if (w_push_vec[v]) r_wr_ptr[v] <= inc_ptr(r_wr_ptr[v]);
                if (w_pop_vec[v])  r_rd_ptr[v] <= inc_ptr(r_rd_ptr[v]);
                r_count[v] <= r_count[v] + N_BITS_CREDIT'(w_push_vec[v])
                                         - N_BITS_CREDIT'(w_pop_vec[v]);
            end
            r_credit <= w_pop_vec;
            r_free   <= w_rd_flit[FLIT_WIDTH-1] ? w_pop_vec : '0;
            if (is_valid_i && !w_push) r_overflow  <= 1'b1;
            if (rd_i && w_rd_empty)    r_underflow <= 1'b1;
        end
    end

    assign credit_signal_o  = r_credit;
    assign free_signal_o    = r_free;
    assign vc_not_empty_o   = w_not_empty;
    assign head_is_header_o = w_header;
    assign rd_flit_o        = w_rd_flit;
    assign overflow_o       = r_overflow;
    assign underflow_o      = r_underflow;

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: a per-cycle vector table plus short
// hand-written sequences for empty write+pop and asynchronous reset.
module tb_router_input_port;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic        clk;
    logic        rst;
    logic [63:0] in_link_i;
    logic        is_valid_i;
    logic [3:0]  credit_signal_o;
    logic [3:0]  free_signal_o;
    logic [3:0]  vc_not_empty_o;
    logic [3:0]  head_is_header_o;
    logic        rd_i;
    logic [1:0]  rd_vc_i;
    logic [63:0] rd_flit_o;
    logic        overflow_o;
    logic        underflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    router_input_port dut (
        .clk              (clk),
        .rst              (rst),
        .in_link_i        (in_link_i),
        .is_valid_i       (is_valid_i),
        .credit_signal_o  (credit_signal_o),
        .free_signal_o    (free_signal_o),
        .vc_not_empty_o   (vc_not_empty_o),
        .head_is_header_o (head_is_header_o),
        .rd_i             (rd_i),
        .rd_vc_i          (rd_vc_i),
        .rd_flit_o        (rd_flit_o),
        .overflow_o       (overflow_o),
        .underflow_o      (underflow_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        wr;
        logic [1:0]  ft;
        logic [1:0]  wvc;
        logic [15:0] wd;
        logic        rd;
        logic [1:0]  rvc;
        logic        cf;
        logic [15:0] ef;
        logic [3:0]  ne;
        logic [3:0]  hh;
        logic [3:0]  cr;
        logic [3:0]  fr;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] mk_flit(input logic [1:0] ft, input logic [1:0] vc,
                                            input logic [15:0] d);
        return {ft, 4'b0, vc, 40'b0, d};
    endfunction

    function automatic vec_t mk_vec(
        input logic r, input logic wr, input logic [1:0] ft, input logic [1:0] wvc,
        input logic [15:0] wd, input logic rd, input logic [1:0] rvc, input logic cf,
        input logic [15:0] ef, input logic [3:0] ne, input logic [3:0] hh,
        input logic [3:0] cr, input logic [3:0] fr, input logic ov, input logic un);
        vec_t t;
        t.rst = r;  t.wr = wr; t.ft = ft; t.wvc = wvc; t.wd = wd;
        t.rd = rd;  t.rvc = rvc; t.cf = cf; t.ef = ef;
        t.ne = ne;  t.hh = hh; t.cr = cr; t.fr = fr; t.ov = ov; t.un = un;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    endtask

    task automatic drive(input logic r, input logic wr, input logic [63:0] f,
                         input logic rd, input logic [1:0] rvc);
        rst        = r;
        is_valid_i = wr;
        in_link_i  = f;
        rd_i       = rd;
        rd_vc_i    = rvc;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] ne, input logic [3:0] hh,
                                 input logic [3:0] cr, input logic [3:0] fr,
                                 input logic ov, input logic un);
        check({tag, " not_empty"}, 64'(vc_not_empty_o),   64'(ne));
        check({tag, " header"},    64'(head_is_header_o), 64'(hh));
        check({tag, " credit"},    64'(credit_signal_o),  64'(cr));
        check({tag, " free"},      64'(free_signal_o),    64'(fr));
        check({tag, " overflow"},  64'(overflow_o),       64'(ov));
        check({tag, " underflow"}, 64'(underflow_o),      64'(un));
    endtask

    initial begin
        // r wr type   wvc  data       rd rvc cf flit      ne     hh     cr     fr    ov un
        // single head+tail flit on VC2
        tbl.push_back(mk_vec(0,1,T_HT,  2,16'hABCD, 0,0, 0,16'h0,    4'b0100,4'b0100,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,2, 1,16'hABCD, 4'b0000,4'b0000,4'b0100,4'b0100,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,0));
        // fill VC1, fifth flit overflows, drain four
        tbl.push_back(mk_vec(0,1,T_HEAD,1,16'h1001, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_BODY,1,16'h1002, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_BODY,1,16'h1003, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_TAIL,1,16'h1004, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_BODY,1,16'h1005, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,1,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,1, 1,16'h1001, 4'b0010,4'b0000,4'b0010,4'b0000,1,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,1, 1,16'h1002, 4'b0010,4'b0000,4'b0010,4'b0000,1,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,1, 1,16'h1003, 4'b0010,4'b0000,4'b0010,4'b0000,1,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,1, 1,16'h1004, 4'b0000,4'b0000,4'b0010,4'b0010,1,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,1,0));
        // reset clears the sticky overflow
        tbl.push_back(mk_vec(1,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,0));
        // full VC0 with same-cycle write and pop, then drain in order (pointer wrap)
        tbl.push_back(mk_vec(0,1,T_HEAD,0,16'h0A01, 0,0, 0,16'h0,    4'b0001,4'b0001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_BODY,0,16'h0A02, 0,0, 0,16'h0,    4'b0001,4'b0001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_BODY,0,16'h0A03, 0,0, 0,16'h0,    4'b0001,4'b0001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_TAIL,0,16'h0A04, 0,0, 0,16'h0,    4'b0001,4'b0001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_BODY,0,16'h0A05, 1,0, 1,16'h0A01, 4'b0001,4'b0000,4'b0001,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,0, 1,16'h0A02, 4'b0001,4'b0000,4'b0001,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,0, 1,16'h0A03, 4'b0001,4'b0000,4'b0001,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,0, 1,16'h0A04, 4'b0001,4'b0000,4'b0001,4'b0001,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,0, 1,16'h0A05, 4'b0000,4'b0000,4'b0001,4'b0000,0,0));
        // interleaved VC0 / VC3 traffic, pops only on VC3 first
        tbl.push_back(mk_vec(0,1,T_HEAD,0,16'h0B01, 0,0, 0,16'h0,    4'b0001,4'b0001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_HT,  3,16'h3C01, 0,0, 0,16'h0,    4'b1001,4'b1001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_TAIL,0,16'h0B02, 1,3, 1,16'h3C01, 4'b0001,4'b0001,4'b1000,4'b1000,0,0));
        tbl.push_back(mk_vec(0,1,T_HEAD,3,16'h3C02, 0,0, 0,16'h0,    4'b1001,4'b1001,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,1,T_TAIL,3,16'h3C03, 1,3, 1,16'h3C02, 4'b1001,4'b0001,4'b1000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,3, 1,16'h3C03, 4'b0001,4'b0001,4'b1000,4'b1000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,0, 1,16'h0B01, 4'b0001,4'b0000,4'b0001,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,0, 1,16'h0B02, 4'b0000,4'b0000,4'b0001,4'b0001,0,0));
        // pop of empty VC2, then reset while VC1 holds two flits
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    1,2, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,1));
        tbl.push_back(mk_vec(0,1,T_HEAD,1,16'h1101, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,0,1));
        tbl.push_back(mk_vec(0,1,T_TAIL,1,16'h1102, 0,0, 0,16'h0,    4'b0010,4'b0010,4'b0000,4'b0000,0,1));
        tbl.push_back(mk_vec(1,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,0));
        tbl.push_back(mk_vec(0,0,T_BODY,0,16'h0,    0,0, 0,16'h0,    4'b0000,4'b0000,4'b0000,4'b0000,0,0));

        drive(1'b1, 1'b0, 64'h0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1 check_outputs("reset held", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 2'd0);
        @(posedge clk);
        #1 check_outputs("reset release", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].wr, mk_flit(tbl[i].ft, tbl[i].wvc, tbl[i].wd),
                  tbl[i].rd, tbl[i].rvc);
            #1;
            if (tbl[i].cf) check($sformatf("vec%0d rd_flit", i), 64'(rd_flit_o[15:0]), 64'(tbl[i].ef));
            @(posedge clk);
            #1 check_outputs($sformatf("vec%0d", i), tbl[i].ne, tbl[i].hh, tbl[i].cr,
                             tbl[i].fr, tbl[i].ov, tbl[i].un);
        end

        // write and pop the same empty VC in one edge: underflow, flit retained
        @(negedge clk);
        drive(1'b0, 1'b1, mk_flit(T_HT, 2'd2, 16'h2222), 1'b1, 2'd2);
        @(posedge clk);
        #1 check_outputs("empty wr+rd", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b1, 2'd2);
        #1 check("empty wr+rd flit", 64'(rd_flit_o[15:0]), 64'h2222);
        @(posedge clk);
        #1 check_outputs("retained pop", 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1);

        // asynchronous reset takes effect without a clock edge
        @(negedge clk);
        drive(1'b0, 1'b1, mk_flit(T_HEAD, 2'd1, 16'h5555), 1'b0, 2'd0);
        @(posedge clk);
        #1 check("async pre not_empty", 64'(vc_not_empty_o), 64'h2);
        @(negedge clk);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 2'd0);
        #1 check_outputs("async reset", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1 check_outputs("async release", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
